// File: rtl/div_iter_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_iter_param_pkg : state encodings shared with the execute stage   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package div_iter_param_pkg;

    localparam int DIV_STATE_W = 2;

    typedef enum logic [DIV_STATE_W-1:0] {
        DIV_FREE  = 2'b00,
        DIV_ON    = 2'b01,
        DIV_FIXUP = 2'b10,
        DIV_END   = 2'b11
    } div_state_e;

    localparam logic DIV_START = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step : one combinational restoring-division step                 |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {rem_i, dvd_bit_i};
    assign w_diff    = w_shifted - {1'b0, dvs_i};
    // Partial remainder is always below the divisor, so the MSB of the
    // difference is a clean borrow flag.
    assign q_bit_o   = ~w_diff[WIDTH];
    assign rem_o     = q_bit_o ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_iter_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_iter_param : multi-cycle signed/unsigned divider, BPC bits/cycle |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module div_iter_param
    import div_iter_param_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               ack_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic               div_zero_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int ITER  = WIDTH / BPC;
    localparam int CNT_W = $clog2(ITER + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic               dz_q, dz_d;
    logic               valid_q, valid_d;
    logic               div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   w_rem_chain [BPC+1];
    logic [BPC-1:0]     w_qbits;
    logic [WIDTH-1:0]   w_dvd_next;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_go;

    assign w_go   = (start_i == DIV_START) && !annul_i;
    assign w_mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // dvd_q shifts the dividend out MSB-first while quotient bits fill in below.
    assign w_rem_chain[0] = rem_q;
    generate
        for (genvar k = 0; k < BPC; k++) begin : g_step
            div_step #(
                .WIDTH (WIDTH)
            ) u_step (
                .rem_i     (w_rem_chain[k]),
                .dvd_bit_i (dvd_q[WIDTH-1-k]),
                .dvs_i     (dvs_q),
                .rem_o     (w_rem_chain[k+1]),
                .q_bit_o   (w_qbits[BPC-1-k])
            );
        end
    endgenerate
    assign w_dvd_next = {dvd_q[WIDTH-1-BPC:0], w_qbits};

    assign w_quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -dvd_q : dvd_q;
    assign w_rem_fix = (sgn_q && neg1_q) ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        sgn_d      = sgn_q;
        neg1_d     = neg1_q;
        neg2_d     = neg2_q;
        dz_d       = dz_q;
        valid_d    = valid_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        case (state_q)
            DIV_FREE: begin
                if (w_go) begin
                    sgn_d  = signed_div_i;
                    neg1_d = opdata1_i[WIDTH-1];
                    neg2_d = opdata2_i[WIDTH-1];
                    dvs_d  = w_mag2;
                    rem_d  = '0;
                    cnt_d  = '0;
                    // A zero divisor skips the iterations and keeps the raw
                    // dividend, reported through the fixup cycle.
                    if (opdata2_i == '0) begin
                        dz_d    = 1'b1;
                        dvd_d   = opdata1_i;
                        state_d = DIV_FIXUP;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = w_mag1;
                        state_d = DIV_ON;
                    end
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    rem_d = w_rem_chain[BPC];
                    dvd_d = w_dvd_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = DIV_FIXUP;
                    end
                end
            end
            DIV_FIXUP: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    valid_d    = 1'b1;
                    div_zero_d = dz_q;
                    result_d   = dz_q ? {dvd_q, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
                    state_d    = DIV_END;
                end
            end
            DIV_END: begin
                if (ack_i || annul_i) begin
                    valid_d    = 1'b0;
                    div_zero_d = 1'b0;
                    result_d   = '0;
                    state_d    = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            sgn_q      <= 1'b0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            dz_q       <= 1'b0;
            valid_q    <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            sgn_q      <= sgn_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            dz_q       <= dz_d;
            valid_q    <= valid_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
        end
    end

    assign busy_o     = (state_q != DIV_FREE);
    assign valid_o    = valid_q;
    assign div_zero_o = div_zero_q;
    assign result_o   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_iter_param : self-checking bench for div_iter_param           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_div_iter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sdiv, start, annul, ack;
    logic [31:0] a, b;
    logic        busy [3];
    logic        valid [3];
    logic        dz [3];
    logic [63:0] res [3];

    logic        s16, st16, an16, ack16;
    logic [15:0] a16, b16;
    logic        busy16, valid16, dz16;
    logic [31:0] res16;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_lat [3];

    div_iter_param #(.WIDTH(32), .BPC(1)) u_bpc1 (
        .clk(clk), .rst(rst), .signed_div_i(sdiv), .opdata1_i(a), .opdata2_i(b),
        .start_i(start), .annul_i(annul), .ack_i(ack), .busy_o(busy[0]),
        .valid_o(valid[0]), .div_zero_o(dz[0]), .result_o(res[0]));
    div_iter_param #(.WIDTH(32), .BPC(2)) u_bpc2 (
        .clk(clk), .rst(rst), .signed_div_i(sdiv), .opdata1_i(a), .opdata2_i(b),
        .start_i(start), .annul_i(annul), .ack_i(ack), .busy_o(busy[1]),
        .valid_o(valid[1]), .div_zero_o(dz[1]), .result_o(res[1]));
    div_iter_param #(.WIDTH(32), .BPC(4)) u_bpc4 (
        .clk(clk), .rst(rst), .signed_div_i(sdiv), .opdata1_i(a), .opdata2_i(b),
        .start_i(start), .annul_i(annul), .ack_i(ack), .busy_o(busy[2]),
        .valid_o(valid[2]), .div_zero_o(dz[2]), .result_o(res[2]));
    div_iter_param #(.WIDTH(16), .BPC(4)) u_w16 (
        .clk(clk), .rst(rst), .signed_div_i(s16), .opdata1_i(a16), .opdata2_i(b16),
        .start_i(st16), .annul_i(an16), .ack_i(ack16), .busy_o(busy16),
        .valid_o(valid16), .div_zero_o(dz16), .result_o(res16));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division on sign-extended 64-bit values.
    function automatic void ref_div(input int w, input logic sg, input logic [31:0] x,
                                    input logic [31:0] y, output logic [63:0] r,
                                    output logic z);
        longint          sx, sy, q, m;
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        if (y == 32'd0) begin
            r = ({32'd0, x} << w) | mask;
            z = 1'b1;
            return;
        end
        sx = longint'({32'd0, x});
        sy = longint'({32'd0, y});
        if (sg && x[w-1]) sx = sx - (longint'(1) << w);
        if (sg && y[w-1]) sy = sy - (longint'(1) << w);
        q = sx / sy;
        m = sx % sy;
        r = ((64'(m) & mask) << w) | (64'(q) & mask);
        z = 1'b0;
    endfunction

    task automatic do_op(input logic sg, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] er, input logic ez, input string nm,
                         input int hold);
        int lat [3];
        bit busy_ok;
        lat     = '{default: 0};
        busy_ok = 1'b1;
        sdiv  = sg;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (valid[i] && lat[i] == 0) lat[i] = c;
            if (lat[0] == 0 && !busy[0]) busy_ok = 1'b0;
        end
        chk({nm, " busy"}, 64'(busy_ok), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s lat%0d", nm, i), 64'(lat[i]), 64'(ez ? 1 : exp_lat[i]));
            chk($sformatf("%s res%0d", nm, i), res[i], er);
            chk($sformatf("%s dz%0d", nm, i), 64'(dz[i]), 64'(ez));
        end
        for (int h = 0; h < hold; h++) begin
            start = (h == 0);
            a     = 32'd0;
            b     = 32'd0;
            @(posedge clk);
            #1 start = 1'b0;
            chk($sformatf("%s hold%0d", nm, h), {res[0][61:0], valid[0], dz[0]},
                {er[61:0], 1'b1, ez});
        end
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s ack flags%0d", nm, i), 64'({valid[i], busy[i], dz[i]}), 64'd0);
            chk($sformatf("%s ack res%0d", nm, i), res[i], 64'd0);
        end
    endtask

    task automatic do_op16(input logic sg, input logic [15:0] x, input logic [15:0] y,
                           input logic [31:0] er, input logic ez, input string nm);
        int lat;
        lat  = 0;
        s16  = sg;
        a16  = x;
        b16  = y;
        st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (valid16) lat = c;
        end
        chk({nm, " lat"}, 64'(lat), 64'(ez ? 1 : 5));
        chk({nm, " res"}, 64'(res16), 64'(er));
        chk({nm, " dz"}, 64'(dz16), 64'(ez));
        ack16 = 1'b1;
        @(posedge clk);
        #1 ack16 = 1'b0;
        chk({nm, " ack"}, 64'({valid16, busy16}), 64'd0);
    endtask

    typedef struct {
        logic        sg;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] er;
        logic        ez;
        string       nm;
        int          hold;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [63:0] er;
        logic        ez;
        logic [31:0] x, y;
        logic        sg;
        bit          saw_valid;

        exp_lat = '{33, 17, 9};
        vt[0]  = '{1'b0, 32'd100,       32'd7,        {32'd2,        32'd14},       1'b0, "u100_7",   0};
        vt[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, "s-7_2",    0};
        vt[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0, "s7_-2",    0};
        vt[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b0, "s_ovf",    0};
        vt[4]  = '{1'b0, 32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF}, 1'b1, "dz_hold",  5};
        vt[5]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 1'b0, "s-100_-7", 0};
        vt[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        {32'h00000000, 32'hFFFFFFFF}, 1'b0, "umax_1",   0};
        vt[7]  = '{1'b0, 32'd5,        32'd10,       {32'd5,        32'd0},        1'b0, "u5_10",    0};
        vt[8]  = '{1'b1, 32'h80000000, 32'd0,        {32'h80000000, 32'hFFFFFFFF}, 1'b1, "s_dz",     0};
        vt[9]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001}, 1'b0, "s-1_-1",   0};
        vt[10] = '{1'b0, 32'hFFFFFFFF, 32'd2,        {32'h00000001, 32'h7FFFFFFF}, 1'b0, "umax_2",   0};

        rst = 1'b0; sdiv = 1'b0; start = 1'b0; annul = 1'b0; ack = 1'b0;
        a = '0; b = '0;
        s16 = 1'b0; st16 = 1'b0; an16 = 1'b0; ack16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset flags%0d", i), 64'({busy[i], valid[i], dz[i]}), 64'd0);
            chk($sformatf("reset res%0d", i), res[i], 64'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) do_op(vt[i].sg, vt[i].x, vt[i].y, vt[i].er, vt[i].ez, vt[i].nm, vt[i].hold);

        // Annul in the middle of the iterations, then an immediate restart.
        sdiv = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        saw_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (valid[0] || valid[1]) saw_valid = 1'b1;
        end
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        chk("annul no valid", 64'(saw_valid), 64'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("annul idle%0d", i), 64'({busy[i], valid[i]}), 64'd0);
        do_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0, "post_annul", 0);

        // Asynchronous reset in the middle of the iterations.
        sdiv = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre-reset busy", 64'(busy[0]), 64'd1);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("async rst calc%0d", i), 64'({busy[i], valid[i], dz[i]}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Asynchronous reset while a result is being held.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        chk("pre-reset valid", 64'(valid[0]), 64'd1);
        rst = 1'b0;
        #1;
        chk("async rst done valid", 64'({valid[0], busy[0]}), 64'd0);
        chk("async rst done res", res[0], 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            sg = 1'($urandom_range(0, 1));
            x  = $urandom;
            case ($urandom_range(0, 9))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = 32'hFFFFFFFF;
                3:       begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(32, sg, x, y, er, ez);
            do_op(sg, x, y, er, ez, $sformatf("rnd%0d", n), 0);
        end

        do_op16(1'b0, 16'hFFFF, 16'h0003, {16'h0000, 16'h5555}, 1'b0, "w16_ffff_3");
        do_op16(1'b1, 16'hABCD, 16'h0000, {16'hABCD, 16'hFFFF}, 1'b1, "w16_dz");
        for (int n = 0; n < 10; n++) begin
            sg = 1'($urandom_range(0, 1));
            x  = {16'd0, 16'($urandom)};
            y  = (n == 3) ? 32'd0 : {16'd0, 16'($urandom >> $urandom_range(0, 15))};
            ref_div(16, sg, x, y, er, ez);
            do_op16(sg, x[15:0], y[15:0], er[31:0], ez, $sformatf("w16_rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
